// File: rtl/aead_seq_pkg.sv
// rtl/aead_seq_pkg.sv - shared widths, defaults and state encoding for the AEAD stream sequencer
package aead_seq_pkg;

    localparam int DATA_W          = 512;
    localparam int KEY_W           = 256;
    localparam int TAG_W           = 128;
    localparam int NONCE_W         = 96;
    localparam int TIMEOUT_DEFAULT = 50000;
    localparam int WD_W            = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_RDY,
        S_FEED,
        S_NEXT,
        S_WAIT_VAL,
        S_DRAIN,
        S_FINAL,
        S_WAIT_TAG,
        S_TAG_OUT,
        S_ERROR
    } state_e;

    function automatic logic is_wait_state(input state_e s);
        return (s == S_WAIT_RDY) || (s == S_WAIT_VAL) || (s == S_WAIT_TAG);
    endfunction

endpackage

// File: rtl/aead_stream_sequencer_if.sv
// rtl/aead_stream_sequencer_if.sv - message, block, tag and core-control signal bundle
interface aead_stream_sequencer_if #(
    parameter int NBLK_W = 8
) ();
    import aead_seq_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_encdec;
    logic [KEY_W-1:0]    cmd_key;
    logic [NONCE_W-1:0]  cmd_nonce;
    logic [NBLK_W-1:0]   cmd_nblocks;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;

    logic                tag_valid;
    logic                tag_ready;
    logic [TAG_W-1:0]    tag;

    logic                err;
    logic                busy;

    logic                core_init;
    logic                core_next;
    logic                core_done;
    logic                core_encdec;
    logic [KEY_W-1:0]    core_key;
    logic [NONCE_W-1:0]  core_nonce;
    logic [DATA_W-1:0]   core_data_in;
    logic                core_ready;
    logic                core_valid;
    logic                core_tag_ok;
    logic [DATA_W-1:0]   core_data_out;
    logic [TAG_W-1:0]    core_tag;

    // master: the host plus the cipher core; slave: the sequencer
    modport master (
        output cmd_valid, cmd_encdec, cmd_key, cmd_nonce, cmd_nblocks,
        output in_valid, in_data, out_ready, tag_ready,
        output core_ready, core_valid, core_tag_ok, core_data_out, core_tag,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, tag_valid, tag,
        input  err, busy, core_init, core_next, core_done, core_encdec,
        input  core_key, core_nonce, core_data_in
    );

    modport slave (
        input  cmd_valid, cmd_encdec, cmd_key, cmd_nonce, cmd_nblocks,
        input  in_valid, in_data, out_ready, tag_ready,
        input  core_ready, core_valid, core_tag_ok, core_data_out, core_tag,
        output cmd_ready, in_ready, out_valid, out_data, out_last, tag_valid, tag,
        output err, busy, core_init, core_next, core_done, core_encdec,
        output core_key, core_nonce, core_data_in
    );

endinterface

// File: rtl/aead_seq_watchdog.sv
// rtl/aead_seq_watchdog.sv - saturating wait-cycle counter flagging a stalled core response
module aead_seq_watchdog #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    import aead_seq_pkg::*;

    logic [WD_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {WD_W{1'b1}})) begin
            count_d = count_q + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the cycle whose increment would make the count reach TIMEOUT
    assign expired_o = enable_i && !clear_i && (count_q == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/aead_stream_sequencer.sv
// rtl/aead_stream_sequencer.sv - sequences one AEAD message through the core, one block in flight
module aead_stream_sequencer #(
    parameter int TIMEOUT = aead_seq_pkg::TIMEOUT_DEFAULT,
    parameter int NBLK_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    aead_stream_sequencer_if.slave bus
);
    import aead_seq_pkg::*;

    state_e              state_q, state_d;
    logic [NBLK_W-1:0]   rem_q, rem_d;
    logic                init_q, next_q, done_q;
    logic                encdec_q;
    logic [KEY_W-1:0]    key_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [DATA_W-1:0]   din_q, dout_q;
    logic [TAG_W-1:0]    tag_q;
    logic                in_wait, wd_expired;
    logic                cmd_fire, in_fire, out_fire, tag_fire;

    assign cmd_fire = bus.cmd_valid && (state_q == S_IDLE);
    assign in_fire  = bus.in_valid  && (state_q == S_FEED);
    assign out_fire = bus.out_ready && (state_q == S_DRAIN);
    assign tag_fire = bus.tag_ready && (state_q == S_TAG_OUT);
    assign in_wait  = is_wait_state(state_q);

    aead_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!in_wait),
        .enable_i  (in_wait),
        .expired_o (wd_expired)
    );

    // Core responses are checked before the watchdog so a last-cycle answer still wins
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = S_INIT;
                    rem_d   = bus.cmd_nblocks;
                end
            end
            S_INIT:     state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (bus.core_ready)  state_d = (rem_q == '0) ? S_FINAL : S_FEED;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_FEED:     if (in_fire) state_d = S_NEXT;
            S_NEXT:     state_d = S_WAIT_VAL;
            S_WAIT_VAL: begin
                if (bus.core_valid)  state_d = S_DRAIN;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_DRAIN: begin
                if (out_fire) begin
                    rem_d   = rem_q - NBLK_W'(1);
                    state_d = (rem_q == NBLK_W'(1)) ? S_FINAL : S_FEED;
                end
            end
            S_FINAL:    state_d = S_WAIT_TAG;
            S_WAIT_TAG: begin
                if (bus.core_tag_ok) state_d = S_TAG_OUT;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_TAG_OUT:  if (tag_fire) state_d = S_IDLE;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_IDLE;
        endcase
    end

    // Pulses are registered from the next state so each lines up with its one-cycle state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            init_q  <= 1'b0;
            next_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            init_q  <= (state_d == S_INIT);
            next_q  <= (state_d == S_NEXT);
            done_q  <= (state_d == S_FINAL);
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            encdec_q <= bus.cmd_encdec;
            key_q    <= bus.cmd_key;
            nonce_q  <= bus.cmd_nonce;
        end
        if (in_fire) begin
            din_q <= bus.in_data;
        end
        if ((state_q == S_WAIT_VAL) && bus.core_valid) begin
            dout_q <= bus.core_data_out;
        end
        if ((state_q == S_WAIT_TAG) && bus.core_tag_ok) begin
            tag_q <= bus.core_tag;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.in_ready     = (state_q == S_FEED);
    assign bus.out_valid    = (state_q == S_DRAIN);
    assign bus.out_last     = (state_q == S_DRAIN) && (rem_q == NBLK_W'(1));
    assign bus.out_data     = dout_q;
    assign bus.tag_valid    = (state_q == S_TAG_OUT);
    assign bus.tag          = tag_q;
    assign bus.err          = (state_q == S_ERROR);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.core_init    = init_q;
    assign bus.core_next    = next_q;
    assign bus.core_done    = done_q;
    assign bus.core_encdec  = encdec_q;
    assign bus.core_key     = key_q;
    assign bus.core_nonce   = nonce_q;
    assign bus.core_data_in = din_q;

endmodule

// File: doc/aead_stream_sequencer.md
AEAD_STREAM_SEQUENCER -- requirements
Module: aead_stream_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 50000: maximum cycles spent waiting on any core response.
REQ-002 Parameter NBLK_W, default 8: width of the block-count field.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  message command handshake.
REQ-006 cmd_encdec, cmd_key, cmd_nonce, cmd_nblocks  in  1/256/96/NBLK_W  per-message encrypt/decrypt flag, key, nonce and 512-bit block count.
REQ-007 in_valid/in_ready/in_data  in/out/in  1/1/512  plaintext or ciphertext block stream.
REQ-008 out_valid/out_ready/out_data/out_last  out/in/out/out  1/1/512/1  processed block stream; out_last marks the final block.
REQ-009 tag_valid/tag_ready/tag  out/in/out  1/1/128  message tag handshake.
REQ-010 err  out  1  sticky timeout flag.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 core_init, core_next, core_done, core_encdec  out  1 each  core controls.
REQ-013 core_key, core_nonce, core_data_in  out  256/96/512  registered core operands.
REQ-014 core_ready, core_valid, core_tag_ok  in  1 each  core status.
REQ-015 core_data_out, core_tag  in  512/128  core results.

Function
REQ-016 FSM states and transitions SHALL be:
- IDLE: cmd_ready=1. On cmd handshake, latch encdec, key, nonce and nblocks into rem; go to INIT.
- INIT: core_init=1 for exactly one cycle; go to WAIT_RDY.
- WAIT_RDY: wait for core_ready, then go to FEED; if rem==0, go to FINAL instead.
- FEED: in_ready=1. On in handshake, register in_data into core_data_in; go to NEXT.
- NEXT: core_next=1 for one cycle; go to WAIT_VAL.
- WAIT_VAL: on core_valid, capture core_data_out into the output register; go to DRAIN.
- DRAIN: out_valid=1, out_last=(rem==1). On out handshake, decrement rem; go to FEED if rem remains nonzero, otherwise go to FINAL.
- FINAL: core_done=1 for one cycle; go to WAIT_TAG.
- WAIT_TAG: on core_tag_ok, capture core_tag; go to TAG_OUT.
- TAG_OUT: tag_valid=1. On tag handshake, return to IDLE.
- ERROR: err=1; all valids, readies and core pulses low; exit only by rst.
REQ-017 Core control pulses SHALL be registered, exactly one cycle wide, and never asserted simultaneously.
REQ-018 Once a valid or ready is asserted, it SHALL hold until its handshake completes; the associated data SHALL remain stable while valid is high.
REQ-019 A watchdog SHALL count cycles in WAIT_RDY, WAIT_VAL and WAIT_TAG; it clears on entry to each of these states.
REQ-020 When the watchdog count reaches TIMEOUT, the FSM SHALL enter ERROR.
REQ-021 A core response arriving on the same cycle the count reaches TIMEOUT SHALL win over the timeout.
REQ-022 Minimum latency from a FEED handshake to out_valid SHALL be 3 cycles plus the core's latency.
REQ-023 A cmd_nblocks value of 0 SHALL be legal: the sequence is INIT, then FINAL, then TAG_OUT, with no in or out handshakes.
REQ-024 Input and output traffic SHALL be strictly one block in flight; in_ready is low from NEXT through DRAIN.

Reset
REQ-025 rst SHALL force IDLE, clear err, rem and the watchdog, and drive every valid, ready and core pulse to 0; data registers may be left unreset.
REQ-026 An rst asserted mid-message SHALL abandon the message; the first output after reset is cmd_ready=1 in the following cycle.

Structure
REQ-027 Package aead_seq_pkg SHALL hold the state enum, the 512/256/128/96 width constants and the TIMEOUT default.
REQ-028 The watchdog SHALL be a sub-module, aead_seq_watchdog, with clear, enable and expired ports and a 16-bit counter.

Verification
REQ-029 Two-block encrypt: key {4{64'h0123456789abcdef}}, nonce {32'h11111111,32'h22222222,32'h33333333}, nblocks=2, blocks {8{64'hcafebabedeadbeef}} then {8{64'h0123456789abcdef}} -> init, next, next, done each seen once; out_last on block 2; one tag_valid; core_key and core_nonce equal the inputs.
REQ-030 Backpressure: out_ready low for 5 cycles in DRAIN -> out_data stable; no second in_ready; rem unchanged.
REQ-031 Timeout: TIMEOUT=16 and the core model never asserts core_valid -> ERROR entered 16 cycles after WAIT_VAL entry; err=1 until rst.
REQ-032 Empty message: nblocks=0 -> no in_ready or out_valid; core_done follows core_ready; tag delivered.
REQ-033 Reset in WAIT_VAL -> next cycle all pulses 0 and cmd_ready=1; a new 1-block command completes normally.
REQ-034 Tag backpressure: tag_ready low for 10 cycles -> tag held stable and cmd_ready stays 0 until the tag handshake completes.
